// File: rtl/packet_generator_if.sv
// Router local-port link: packet bus plus request/full/grant handshake.
// The master side is the traffic source, the slave side the router port.
interface packet_generator_if #(
  parameter int unsigned dataWidth = 32
);
  logic [dataWidth-1:0] PacketOut;
  logic                 ReqDnStr;
  logic                 DnStrFull;
  logic                 GntDnStr;

  modport master (output PacketOut, output ReqDnStr, input DnStrFull, input GntDnStr);
  modport slave  (input PacketOut, input ReqDnStr, output DnStrFull, output GntDnStr);
endinterface

// File: rtl/packet_generator.sv
// Mesh NoC traffic source: injects {dest, PacketID, ModuleID} packets into a router local port.
// Define GEN_RANDOM_DEST_EN to draw destinations from an 8-bit LFSR instead of the fixed DestID.
module packet_generator #(
  parameter logic [5:0]  ModuleID       = 6'b000_000,
  parameter logic [5:0]  DestID         = 6'b000_010,
  parameter int unsigned dataWidth      = 32,
  parameter int unsigned dim            = 4,
  parameter int unsigned NumPackets     = 16,
  parameter logic [15:0] InjectInterval = 16'd4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  packet_generator_if.master  pkt,
  output logic [15:0]         SentCount,
  output logic                Done
);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, SEND_REQ, DONE} state_t;

  state_t               state_q, state_d;
  logic [dataWidth-1:0] packet_q, packet_d;
  logic [9:0]           pkt_id_q, pkt_id_d;
  logic [15:0]          sent_q, sent_d;
  logic [15:0]          gap_q, gap_d;
  logic                 done_q, done_d;
  logic [5:0]           dest;
  logic                 req;
  logic                 grant;

  if (dataWidth < 22) begin : g_width_check
    $error("packet_generator: dataWidth must be at least 22");
  end
  if (dim < 1 || dim > 8) begin : g_dim_check
    $error("packet_generator: dim must be within 1..8");
  end

  // Request follows DnStrFull combinationally so a full port withholds it in the same cycle.
  assign req           = (state_q == SEND_REQ) && !pkt.DnStrFull;
  assign grant         = req && pkt.GntDnStr;
  assign pkt.ReqDnStr  = req;
  assign pkt.PacketOut = packet_q;
  assign SentCount     = sent_q;
  assign Done          = done_q;

`ifdef GEN_RANDOM_DEST_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] dest_x, dest_y;

  always_comb begin
    lfsr_d = lfsr_q;
    if (grant) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    dest_x = {1'b0, lfsr_q[1:0]};
    dest_y = {1'b0, lfsr_q[3:2]};
    // Never address ourselves: bump y, staying inside the mesh.
    if ({dest_x, dest_y} == ModuleID) dest_y = 3'((32'(dest_y) + 32'd1) % dim);
  end

  assign dest = {dest_x, dest_y};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign dest = DestID;
`endif

  always_comb begin
    state_d  = state_q;
    packet_d = packet_q;
    pkt_id_d = pkt_id_q;
    sent_d   = sent_q;
    gap_d    = gap_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        if (Enable) begin
          packet_d        = '0;
          packet_d[21:16] = dest;
          packet_d[15:6]  = pkt_id_q;
          packet_d[5:0]   = ModuleID;
          state_d         = SEND_REQ;
        end
      end
      SEND_REQ: begin
        if (grant) begin
          pkt_id_d = pkt_id_q + 10'd1;
          sent_d   = sent_q + 16'd1;
          gap_d    = InjectInterval;
          if (NumPackets != 0 && sent_d == 16'(NumPackets)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (InjectInterval == '0) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_GAP;
          end
        end
      end
      WAIT_GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else if (Enable) begin
          gap_d = gap_q - 16'd1;
          if (gap_q == 16'd1) state_d = IDLE;
        end
      end
      DONE: done_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      packet_q <= '0;
      pkt_id_q <= '0;
      sent_q   <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      packet_q <= packet_d;
      pkt_id_q <= pkt_id_d;
      sent_q   <= sent_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_packet_generator.sv
// Bench for packet_generator: hand-derived vector table, corner sequences and randomized
// traffic checked against a request/grant-level reference model.
module tb_packet_generator;

  localparam logic [5:0]  MOD_A = 6'b000_000;
  localparam logic [5:0]  DST_A = 6'b000_010;
  localparam logic [5:0]  MOD_B = 6'b001_010;
  localparam logic [5:0]  DST_B = 6'b011_001;
  localparam int unsigned NUM_A = 3;
  localparam int unsigned NUM_B = 0;
  localparam int unsigned GAP_A = 4;
  localparam int unsigned GAP_B = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a, en_b;
  logic [15:0] sent_a, sent_b;
  logic        done_a, done_b;

  packet_generator_if #(.dataWidth(32)) if_a ();
  packet_generator_if #(.dataWidth(32)) if_b ();

  packet_generator #(
    .ModuleID(MOD_A), .DestID(DST_A), .dataWidth(32), .dim(4),
    .NumPackets(NUM_A), .InjectInterval(16'(GAP_A))
  ) dut_a (
    .clk(clk), .reset(reset), .Enable(en_a), .pkt(if_a), .SentCount(sent_a), .Done(done_a)
  );

  packet_generator #(
    .ModuleID(MOD_B), .DestID(DST_B), .dataWidth(32), .dim(4),
    .NumPackets(NUM_B), .InjectInterval(16'(GAP_B))
  ) dut_b (
    .clk(clk), .reset(reset), .Enable(en_b), .pkt(if_b), .SentCount(sent_b), .Done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a packet becomes pending after a number of enabled cycles.
  int         sel;
  bit         m_pend;
  int         m_wait;
  int         m_sent;
  int         m_id;
  bit         m_done;
  int         m_gap;
  int         m_num;
  logic [5:0] m_mod, m_dst;

  typedef struct {
    bit en; bit full; bit gnt;
    bit req; int sent; bit done; int id;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic dut_req();
    return (sel == 0) ? if_a.ReqDnStr : if_b.ReqDnStr;
  endfunction
  function automatic logic [31:0] dut_pkt();
    return (sel == 0) ? if_a.PacketOut : if_b.PacketOut;
  endfunction
  function automatic logic [15:0] dut_sent();
    return (sel == 0) ? sent_a : sent_b;
  endfunction
  function automatic logic dut_done();
    return (sel == 0) ? done_a : done_b;
  endfunction

  task automatic drive(input bit en, input bit full, input bit gnt);
    if (sel == 0) begin
      en_a = en; if_a.DnStrFull = full; if_a.GntDnStr = gnt;
      en_b = 1'b0; if_b.DnStrFull = 1'b0; if_b.GntDnStr = 1'b0;
    end else begin
      en_b = en; if_b.DnStrFull = full; if_b.GntDnStr = gnt;
      en_a = 1'b0; if_a.DnStrFull = 1'b0; if_a.GntDnStr = 1'b0;
    end
  endtask

  task automatic model_reset(input int s);
    sel    = s;
    m_gap  = (s == 0) ? GAP_A : GAP_B;
    m_num  = (s == 0) ? NUM_A : NUM_B;
    m_mod  = (s == 0) ? MOD_A : MOD_B;
    m_dst  = (s == 0) ? DST_A : DST_B;
    m_pend = 1'b0;
    m_wait = 1;
    m_sent = 0;
    m_id   = 0;
    m_done = 1'b0;
  endtask

  task automatic reset_dut(input int s);
    sel = s;
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset(s);
  endtask

  task automatic chk_pkt(input string name, input logic [31:0] act, input int id);
    logic [31:0] exp;
    exp = {10'd0, m_dst, 10'(id), m_mod};
`ifdef GEN_RANDOM_DEST_EN
    chk(name, act & 32'hFFC0_FFFF, exp & 32'hFFC0_FFFF);
    chk({name, "_dest"}, {31'd0, act[21] | act[18] | (act[21:16] == m_mod)}, 32'd0);
`else
    chk(name, act, exp);
`endif
  endtask

  task automatic cycle(input bit en, input bit full, input bit gnt);
    bit req;
    drive(en, full, gnt);
    req = m_pend && !full && !m_done;
    if (req && gnt) begin
      m_sent++;
      m_id   = (m_id + 1) % 1024;
      m_pend = 1'b0;
      m_wait = m_gap + 1;
      if (m_num != 0 && m_sent == m_num) m_done = 1'b1;
    end else if (!m_pend && !m_done && en) begin
      m_wait--;
      if (m_wait == 0) m_pend = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("req", dut_req(), m_pend && !full && !m_done);
    chk("sent", dut_sent(), 16'(m_sent));
    chk("done", dut_done(), m_done);
    if (m_pend) chk_pkt("pkt", dut_pkt(), m_id);
  endtask

  initial begin
    int          n;
    bit          seen;
    logic [31:0] p;

    reset = 1'b0;
    sel   = 0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset(0);
    @(negedge clk);
    chk("rst_req_a", if_a.ReqDnStr, 0);
    chk("rst_pkt_a", if_a.PacketOut, 0);
    chk("rst_sent_a", sent_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_req_b", if_b.ReqDnStr, 0);
    chk("rst_sent_b", sent_b, 0);

    // Three-packet run with grant one cycle after request, plus ignored grants.
    tbl.push_back('{1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 2, 0, 1});
    tbl.push_back('{1, 0, 0, 1, 2, 0, 2});
    tbl.push_back('{1, 0, 1, 0, 3, 1, 2});
    tbl.push_back('{1, 0, 1, 0, 3, 1, 2});
    tbl.push_back('{1, 0, 0, 0, 3, 1, 2});
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].full, tbl[i].gnt);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), dut_req(), tbl[i].req);
      chk($sformatf("tbl%0d_sent", i), dut_sent(), 16'(tbl[i].sent));
      chk($sformatf("tbl%0d_done", i), dut_done(), tbl[i].done);
      chk_pkt($sformatf("tbl%0d_pkt", i), dut_pkt(), tbl[i].id);
    end

    // Full port for 10 cycles: request withheld, packet held, then resumes.
    reset_dut(0);
    cycle(1, 0, 0);
    p = dut_pkt();
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 1);
      chk("full_req_low", dut_req(), 0);
      chk("full_pkt_hold", dut_pkt(), p);
    end
    cycle(1, 0, 0);
    chk("full_resume", dut_req(), 1);

    // Enable low for 5 cycles in the gap delays the next request by 5 cycles.
    reset_dut(0);
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      n++;
    end
    while (!seen && n < 40) begin
      cycle(1, 0, 0);
      n++;
      if (dut_req()) seen = 1'b1;
    end
    chk("gap_delay", n, 10);

    // Reset while requesting: drops at once, nothing counted, restart from PacketID 0.
    reset_dut(0);
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    n = 0;
    while (!dut_req() && n < 20) begin
      cycle(1, 0, 0);
      n++;
    end
    chk("pre_rst_req", dut_req(), 1);
    chk("pre_rst_sent", dut_sent(), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_req", if_a.ReqDnStr, 0);
    chk("rst_async_sent", sent_a, 0);
    chk("rst_async_pkt", if_a.PacketOut, 0);
    chk("rst_async_done", done_a, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset(0);
    cycle(1, 0, 0);
    p = dut_pkt();
    chk("rst_first_id", {22'd0, p[15:6]}, 0);

    // Unlimited mode, zero gap: PacketID wraps after 1023, Done never rises.
    reset_dut(1);
    seen = 1'b0;
    n = 0;
    while (m_sent < 1030 && n < 3000) begin
      cycle(1, 0, 1);
      n++;
      if (m_sent == 1024 && m_pend && !seen) begin
        p = dut_pkt();
        chk("wrap_id", {22'd0, p[15:6]}, 0);
        seen = 1'b1;
      end
    end
    chk("wrap_seen", seen, 1);
    chk("wrap_count", sent_b, 16'd1030);
    chk("wrap_done_low", done_b, 0);

    // Randomized traffic on both configurations.
    reset_dut(1);
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    reset_dut(0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
